// File: rtl/dmem_if.sv
// Request/response bus between the control unit and the data-memory responder.
// DMEM_WSTRB_EN adds the per-byte write-enable field.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef DMEM_WSTRB_EN
    logic [3:0]  wstrb;
`endif
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

`ifdef DMEM_WSTRB_EN
    modport master (
        output req_valid, req_we, addr, wdata, wstrb,
        input  req_ready, rsp_valid, rdata, err
    );
    modport slave (
        input  req_valid, req_we, addr, wdata, wstrb,
        output req_ready, rsp_valid, rdata, err
    );
`else
    modport master (
        output req_valid, req_we, addr, wdata,
        input  req_ready, rsp_valid, rdata, err
    );
    modport slave (
        input  req_valid, req_we, addr, wdata,
        output req_ready, rsp_valid, rdata, err
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Multicycle big-endian data-memory responder: one request at a time,
// IDLE -> ACCESS -> RESP, registered rdata/err held until the next access.
// Optional feature macro: DMEM_WSTRB_EN (per-byte store strobes).
module dmem_responder #(
    parameter int unsigned DEPTH_BYTES = 128
) (
    input logic   CLK,
    input logic   RST,
    dmem_if.slave bus
);

    // Byte index width; aligned in-range words never carry past this width.
    localparam int unsigned AW = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        rsp_valid_q;
    logic [3:0]  strb;

    logic [7:0]  mem [DEPTH_BYTES];

    logic          bad;
    logic          do_write;
    logic [AW-1:0] base;

`ifdef DMEM_WSTRB_EN
    logic [3:0] strb_q;

    // Capture strobes alongside the rest of the request.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == StIdle && bus.req_valid) begin
            strb_q <= bus.wstrb;
        end
    end

    assign strb = strb_q;
`else
    assign strb = 4'hF;
`endif

    // Misaligned or any byte of the word beyond the array (full 32-bit compare).
    assign bad      = (addr_q[1:0] != 2'b00) || (addr_q > (DEPTH_BYTES - 32'd4));
    assign base     = addr_q[AW-1:0];
    // Reset on the ACCESS edge suppresses the store.
    assign do_write = (state_q == StAccess) && we_q && !bad && !RST;

    // Control FSM with registered response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rsp_valid_q <= 1'b0;
                    if (bus.req_valid) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        we_q    <= bus.req_we;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (bad) begin
                        err_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= 32'd0;
                        end
                    end else begin
                        err_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= {mem[base], mem[base + AW'(1)],
                                        mem[base + AW'(2)], mem[base + AW'(3)]};
                        end
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    // Byte array write port; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[3-i]) begin
                    mem[base + AW'(i)] <= wdata_q[31-8*i -: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: the driver applies each accepted
// request to a byte-array reference model and queues the expected response; a
// negedge monitor pops and compares every rsp_valid pulse.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 128;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    dmem_if bus();

    dmem_responder #(.DEPTH_BYTES(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    logic        rst_at_edge = 1'b1;
    bit          mon_en = 1'b0;

    // Reference model: byte array plus the last response word/flag.
    logic [7:0]  mm [DEPTH];
    logic [31:0] m_rdata = 32'd0;
    logic        m_err = 1'b0;

    initial forever begin
        @(posedge CLK);
        cyc++;
        rst_at_edge = RST;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (a[1:0] != 2'b00 || a > DEPTH - 4) begin
            m_err = 1'b1;
            if (!we) m_rdata = 32'd0;
        end else begin
            m_err = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (we && s[3-i]) mm[a + 32'(i)] = d[31-8*i -: 8];
            end
            if (!we) m_rdata = {mm[a], mm[a + 32'd1], mm[a + 32'd2], mm[a + 32'd3]};
        end
    endtask

    function automatic logic [3:0] rstrb();
`ifdef DMEM_WSTRB_EN
        return 4'($urandom_range(0, 15));
`else
        return 4'hF;
`endif
    endfunction

    function automatic logic [31:0] raddr();
        int unsigned k;
        k = $urandom_range(0, 5);
        if (k == 0) return 32'($urandom_range(0, DEPTH + 12));
        if (k == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, DEPTH / 4 - 1)) << 2;
    endfunction

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.addr      = a;
        bus.wdata     = d;
`ifdef DMEM_WSTRB_EN
        bus.wstrb     = s;
`endif
    endtask

    // One request; expected response seen at the negedge two edges after this one.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int n = 0;
        @(negedge CLK);
        drive(we, a, d, s);
        while (!bus.req_ready && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
        end else begin
            model(we, a, d, s);
            sb.push_back('{m_rdata, m_err, cyc + 2});
        end
        @(posedge CLK);
        #1 bus.req_valid = 1'b0;
    endtask

    // Store whose ACCESS edge coincides with reset: must vanish entirely.
    task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge CLK);
        drive(1'b1, a, d, 4'hF);
        while (!bus.req_ready && n < 10) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        m_rdata = 32'd0;
        m_err   = 1'b0;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (3) begin
            @(negedge CLK);
            chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    // req_valid held high with a fresh address every cycle.
    task automatic busy_run();
        int          acc = 0;
        int          n = 0;
        int unsigned last = 0;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        while (acc < 8 && n < 100) begin
            @(negedge CLK);
            we = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, DEPTH / 4 - 1)) << 2;
            d  = $urandom;
            s  = rstrb();
            drive(we, a, d, s);
            if (bus.req_ready) begin
                if (acc > 0) chk("busy_spacing", cyc - last, 32'd3);
                last = cyc;
                acc++;
                model(we, a, d, s);
                sb.push_back('{m_rdata, m_err, cyc + 2});
            end
            n++;
        end
        chk("busy_accept_count", 32'(acc), 32'd8);
        @(posedge CLK);
        #1 bus.req_valid = 1'b0;
    endtask

    // Monitor: pop on every response, otherwise rdata/err must hold.
    initial begin
        logic [31:0] h_rdata = 32'd0;
        logic        h_err = 1'b0;
        exp_t        e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (rst_at_edge) begin
                    sb.delete();
                    h_rdata = 32'd0;
                    h_err   = 1'b0;
                end
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)",
                                 cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_cycle", cyc, e.cyc);
                        chk("rsp_rdata", bus.rdata, e.rdata);
                        chk("rsp_err", 32'(bus.err), 32'(e.err));
                        chk("rsp_ready_low", 32'(bus.req_ready), 32'd0);
                        h_rdata = e.rdata;
                        h_err   = e.err;
                    end
                end else begin
                    chk("hold_rdata", bus.rdata, h_rdata);
                    chk("hold_err", 32'(bus.err), 32'(h_err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
`ifdef DMEM_WSTRB_EN
        bus.wstrb     = 4'h0;
`endif
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST    = 1'b0;
        mon_en = 1'b1;
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        repeat (10) begin
            @(negedge CLK);
            chk("idle_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Give every byte a known value.
        for (int i = 0; i < int'(DEPTH / 4); i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);

        // Round trip and byte order.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b1, 32'h0C, 32'h11223344, 4'hF);
        issue(1'b0, 32'h0C, 32'h0, 4'h0);
        issue(1'b0, 32'h10, 32'h0, 4'h0);

        // Bad and boundary addresses.
        issue(1'b0, 32'h12, 32'h0, 4'h0);
        issue(1'b1, 32'h7C, 32'h5A5A1234, 4'hF);
        issue(1'b1, 32'h80, 32'h99999999, 4'hF);
        issue(1'b0, 32'h7C, 32'h0, 4'h0);
        issue(1'b1, 32'h7E, 32'h77777777, 4'hF);
        issue(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
        issue(1'b0, 32'h7C, 32'h0, 4'h0);

        // Reset on the ACCESS edge of a store.
        issue(1'b1, 32'h20, 32'h00000000, 4'hF);
        reset_mid_store(32'h20, 32'hCAFEF00D);
        issue(1'b0, 32'h20, 32'h0, 4'h0);

`ifdef DMEM_WSTRB_EN
        issue(1'b1, 32'h30, 32'hAABBCCDD, 4'b1111);
        issue(1'b1, 32'h30, 32'h11223344, 4'b0101);
        issue(1'b0, 32'h30, 32'h0, 4'hF);
        issue(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000);
        issue(1'b0, 32'h30, 32'h0, 4'h0);
`endif

        busy_run();

        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), raddr(), $urandom, rstrb());
        end

        repeat (5) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
